// File: rtl/trace_match_packer.sv
// rtl/trace_match_packer.sv - serialises masked trace rule matches into timestamped sniff FIFO entries
module trace_match_packer #(
    parameter int pRULES         = 8,
    parameter int pSHORTTIME_LEN = 8,
    parameter int pFULLTIME_LEN  = 24,
    parameter int pQDEPTH        = 4
) (
    input  logic                       trace_clk,
    input  logic                       reset,
    input  logic                       enable_i,
    input  logic [pRULES-1:0]          match_i,
    input  logic [pRULES-1:0]          pattern_enable_i,
    input  logic [pRULES-1:0]          trig_enable_i,
    output logic [pFULLTIME_LEN+1:0]   out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    input  logic                       clear_overflow,
    output logic                       overflow,
    output logic                       trig_out,
    output logic                       idle
);

    localparam int AW = $clog2(pQDEPTH);
    localparam logic [pFULLTIME_LEN-1:0] DELTA_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TIME,
        S_MATCH
    } state_t;

    state_t state, next_state;

    logic [pFULLTIME_LEN-1:0] delta;
    logic [pRULES-1:0]        cap_mask;
    logic                     capture;
    logic                     push;
    logic                     pop;
    logic                     drop;
    logic                     accept;

    logic [pRULES-1:0]        q_mask  [pQDEPTH];
    logic [pFULLTIME_LEN-1:0] q_delta [pQDEPTH];
    logic [AW:0]              wr_ptr;
    logic [AW:0]              rd_ptr;
    logic                     q_empty;
    logic                     q_full;
    logic [pRULES-1:0]        head_mask;
    logic [pFULLTIME_LEN-1:0] head_delta;

    logic [pRULES-1:0]        work_mask;
    logic [pRULES-1:0]        work_mask_rest;
    logic [pFULLTIME_LEN-1:0] work_delta;
    logic [7:0]               low_idx;

    assign cap_mask = match_i & pattern_enable_i;
    assign capture  = enable_i & (|cap_mask);

    assign q_empty    = (wr_ptr == rd_ptr);
    assign q_full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_mask  = q_mask[rd_ptr[AW-1:0]];
    assign head_delta = q_delta[rd_ptr[AW-1:0]];

    // A pop in the same cycle frees the slot, so a full queue still accepts the push.
    assign pop    = (state == S_IDLE) && !q_empty;
    assign push   = capture && (!q_full || pop);
    assign drop   = capture && !push;
    assign accept = out_valid && out_ready;

    assign work_mask_rest = work_mask & (work_mask - 1'b1);
    assign idle           = q_empty && (state == S_IDLE);

    always_ff @(posedge trace_clk) begin
        if (push) begin
            q_mask[wr_ptr[AW-1:0]]  <= cap_mask;
            q_delta[wr_ptr[AW-1:0]] <= delta;
        end
    end

    always_ff @(posedge trace_clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Delta restarts at 1 after a successful push so it measures capture-to-capture;
    // dropped captures leave it running.
    always_ff @(posedge trace_clk or posedge reset) begin
        if (reset) begin
            delta <= '0;
        end else if (!enable_i) begin
            delta <= '0;
        end else if (push) begin
            delta <= DELTA_ONE;
        end else if (~&delta) begin
            delta <= delta + 1'b1;
        end
    end

    always_ff @(posedge trace_clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
            trig_out <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
            trig_out <= enable_i && (|(match_i & trig_enable_i));
        end
    end

    always_ff @(posedge trace_clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            work_mask  <= '0;
            work_delta <= '0;
        end else begin
            state <= next_state;
            if (pop) begin
                work_mask  <= head_mask;
                work_delta <= head_delta;
            end else if (accept && state == S_TIME) begin
                work_delta <= '0;
            end else if (accept && state == S_MATCH) begin
                work_mask  <= work_mask_rest;
                work_delta <= '0;
            end
        end
    end

    always_comb begin
        low_idx = 8'd0;
        for (int i = pRULES - 1; i >= 0; i--) begin
            if (work_mask[i]) low_idx = 8'(i);
        end
    end

    always_comb begin
        next_state = state;
        out_valid  = 1'b0;
        out_data   = '0;
        case (state)
            S_IDLE: begin
                if (!q_empty) begin
                    next_state = (|head_delta[pFULLTIME_LEN-1:pSHORTTIME_LEN]) ? S_TIME : S_MATCH;
                end
            end
            S_TIME: begin
                out_valid = 1'b1;
                out_data  = {work_delta, 2'b01};
                if (out_ready) next_state = S_MATCH;
            end
            S_MATCH: begin
                out_valid = 1'b1;
                out_data[1:0]                                  = 2'b00;
                out_data[pSHORTTIME_LEN+1:2]                   = work_delta[pSHORTTIME_LEN-1:0];
                out_data[pSHORTTIME_LEN+9:pSHORTTIME_LEN+2]    = low_idx;
                if (out_ready && work_mask_rest == '0) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_trace_match_packer.sv
// tb/tb_trace_match_packer.sv - scoreboard bench for trace_match_packer
module tb_trace_match_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable_i;
    logic [7:0]  match_i;
    logic [7:0]  pattern_enable_i;
    logic [7:0]  trig_enable_i;
    logic [25:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        clear_overflow;
    logic        overflow;
    logic        trig_out;
    logic        idle;

    typedef struct {
        string       tag;
        logic [25:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_cap;
    int          n;
    int          c;
    int          d;
    logic        hold = 1'b0;
    logic [25:0] hold_data;

    trace_match_packer dut (
        .trace_clk        (clk),
        .reset            (reset),
        .enable_i         (enable_i),
        .match_i          (match_i),
        .pattern_enable_i (pattern_enable_i),
        .trig_enable_i    (trig_enable_i),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .clear_overflow   (clear_overflow),
        .overflow         (overflow),
        .trig_out         (trig_out),
        .idle             (idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [25:0] m_ent(input int rule, input int dl);
        return (26'(rule) << 10) | (26'(dl) << 2);
    endfunction

    function automatic logic [25:0] t_ent(input int dl);
        return (26'(dl) << 2) | 26'd1;
    endfunction

    task automatic expect_entry(input string tag, input logic [25:0] data, input int at);
        exp_t e;
        e.tag  = tag;
        e.data = data;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic do_match(input logic [7:0] m);
        match_i = m;
        last_cap = cyc;
        tick(1);
        match_i = '0;
    endtask

    task automatic wait_drain(input int max);
        for (int i = 0; i < max && !(sb.size() == 0 && idle); i++) tick(1);
        check_eq("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    // Outputs are sampled on the falling edge; the accepted entry is whatever is
    // on out_data when out_ready is high for the coming rising edge.
    always @(negedge clk) begin
        if (reset) begin
            hold = 1'b0;
        end else begin
            if (hold && out_valid) check_eq("hold_stable", 64'(out_data), 64'(hold_data));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("extra_entry", 64'(out_valid), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check_eq(mon_e.tag, 64'(out_data), 64'(mon_e.data));
                    if (mon_e.cyc >= 0) check_eq({mon_e.tag, "_cyc"}, 64'(cyc), 64'(mon_e.cyc));
                end
                hold = 1'b0;
            end else if (out_valid) begin
                hold      = 1'b1;
                hold_data = out_data;
            end else begin
                hold = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b1;
        enable_i         = 1'b0;
        match_i          = '0;
        pattern_enable_i = '0;
        trig_enable_i    = '0;
        out_ready        = 1'b1;
        clear_overflow   = 1'b0;
        last_cap         = 0;
        tick(2);
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_data", 64'(out_data), 64'd0);
        check_eq("rst_ovf", 64'(overflow), 64'd0);
        check_eq("rst_trig", 64'(trig_out), 64'd0);
        check_eq("rst_idle", 64'(idle), 64'd1);
        reset = 1'b0;
        tick(2);

        // single match 10 cycles after arming
        pattern_enable_i = 8'hFF;
        enable_i         = 1'b1;
        tick(10);
        expect_entry("t1_match", m_ent(1, 10), cyc + 2);
        do_match(8'h02);
        wait_drain(20);

        // simultaneous matches serialise lowest rule first
        tick(5);
        n = cyc;
        d = cyc - last_cap;
        expect_entry("t2_r2", m_ent(2, d), n + 2);
        expect_entry("t2_r5", m_ent(5, 0), n + 3);
        expect_entry("t2_r7", m_ent(7, 0), n + 4);
        do_match(8'hA4);
        wait_drain(20);

        // long gap produces a TIME entry first
        tick(300 - (cyc - last_cap));
        n = cyc;
        expect_entry("t3_time", t_ent(300), n + 2);
        expect_entry("t3_match", m_ent(0, 0), n + 3);
        do_match(8'h01);
        wait_drain(20);

        // one entry parks in the output stage, then five back-to-back captures
        out_ready = 1'b0;
        tick(2);
        expect_entry("t4_park", m_ent(0, cyc - last_cap), -1);
        do_match(8'h01);
        tick(2);
        c = cyc;
        expect_entry("t4_q0", m_ent(1, c - last_cap), -1);
        expect_entry("t4_q1", m_ent(2, 1), -1);
        expect_entry("t4_q2", m_ent(3, 1), -1);
        expect_entry("t4_q3", m_ent(4, 1), -1);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) check_eq("t4_ovf_before", 64'(overflow), 64'd0);
            match_i = 8'(8'h02 << i);
            tick(1);
        end
        match_i  = '0;
        last_cap = c + 3;
        check_eq("t4_ovf_set", 64'(overflow), 64'd1);
        check_eq("t4_not_idle", 64'(idle), 64'd0);
        tick(3);
        out_ready = 1'b1;
        wait_drain(30);
        check_eq("t4_ovf_sticky", 64'(overflow), 64'd1);
        expect_entry("t4_after_drop", m_ent(6, cyc - last_cap), -1);
        do_match(8'h40);
        wait_drain(20);
        clear_overflow = 1'b1;
        tick(1);
        clear_overflow = 1'b0;
        check_eq("t4_ovf_clear", 64'(overflow), 64'd0);

        // trigger path is independent of the capture mask
        pattern_enable_i = 8'h00;
        trig_enable_i    = 8'h02;
        tick(1);
        check_eq("t5_trig_pre", 64'(trig_out), 64'd0);
        match_i = 8'h02;
        tick(1);
        match_i = '0;
        check_eq("t5_trig_hi", 64'(trig_out), 64'd1);
        tick(1);
        check_eq("t5_trig_lo", 64'(trig_out), 64'd0);
        tick(4);
        check_eq("t5_no_entry", 64'(idle), 64'd1);

        // reset while an entry is being presented
        pattern_enable_i = 8'hFF;
        trig_enable_i    = 8'h00;
        out_ready        = 1'b0;
        do_match(8'h0F);
        tick(3);
        check_eq("t6_valid_before", 64'(out_valid), 64'd1);
        #3;
        reset = 1'b1;
        #1;
        check_eq("t6_valid", 64'(out_valid), 64'd0);
        check_eq("t6_idle", 64'(idle), 64'd1);
        check_eq("t6_ovf", 64'(overflow), 64'd0);
        check_eq("t6_data", 64'(out_data), 64'd0);
        tick(2);
        reset     = 1'b0;
        out_ready = 1'b1;
        tick(20);
        check_eq("t6_idle_after", 64'(idle), 64'd1);

        check_eq("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
